// File: rtl/peak_readout.sv
// peak_readout: snapshots a frame of peak words from the histogram builder and
// serializes it as one header word (frame counter) followed by PIX pixel words
// over a valid/ready stream. A frame strobe is accepted in IDLE or on the cycle
// the last pixel word transfers. A strobe at any other time is dropped, and the
// drop is flagged on the sticky overrun output.

module peak_readout #(
    parameter int NP  = 10,
    parameter int PIX = 3
) (
    input  logic              clk,
    input  logic              res,
    input  logic [NP*PIX-1:0] peakIn,
    input  logic              peakValid,
    output logic [NP-1:0]     outData,
    output logic              outValid,
    input  logic              outReady,
    output logic              outSof,
    output logic              outEof,
    output logic              busy,
    output logic              overrun,
    input  logic              clrOvr
);

    localparam int IW = (PIX > 1) ? $clog2(PIX) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PIX - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} stateT;

    stateT          state;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  idxNext;
    logic [NP-1:0]  frameCnt;
    logic [NP-1:0]  shadow   [PIX];
    logic [NP-1:0]  peakWord [PIX];

    logic xfer;
    logic lastXfer;
    logic accept;
    logic drop;

    // Unpack the flat peak bus into one word per pixel.
    generate
        for (genvar gi = 0; gi < PIX; gi++) begin : g_unpack
            assign peakWord[gi] = peakIn[gi*NP +: NP];
        end
    endgenerate

    assign xfer     = outValid & outReady;
    assign lastXfer = (state == DATA) && xfer && (idx == LAST_IDX);
    // The last-pixel transfer frees the shadow on the same edge, so a strobe
    // there can be taken without an idle bubble.
    assign accept   = peakValid && ((state == IDLE) || lastXfer);
    assign drop     = peakValid && !accept;
    assign idxNext  = idx + 1'b1;
    assign busy     = (state != IDLE);

    // Frame FSM with registered stream outputs, shadow capture and overrun flag.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state    <= IDLE;
            idx      <= '0;
            frameCnt <= '0;
            outData  <= '0;
            outValid <= 1'b0;
            outSof   <= 1'b0;
            outEof   <= 1'b0;
            overrun  <= 1'b0;
            for (int i = 0; i < PIX; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            // A drop in the same cycle as a clear wins, so no drop goes unreported.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clrOvr) begin
                overrun <= 1'b0;
            end

            if (accept) begin
                for (int i = 0; i < PIX; i++) begin
                    shadow[i] <= peakWord[i];
                end
            end

            case (state)
                IDLE: begin
                    if (peakValid) begin
                        state    <= HDR;
                        outValid <= 1'b1;
                        outSof   <= 1'b1;
                        outEof   <= 1'b0;
                        outData  <= frameCnt;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state   <= DATA;
                        idx     <= '0;
                        outSof  <= 1'b0;
                        outEof  <= (LAST_IDX == '0);
                        outData <= shadow[0];
                    end
                end
                DATA: begin
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            frameCnt <= frameCnt + 1'b1;
                            idx      <= '0;
                            outEof   <= 1'b0;
                            if (peakValid) begin
                                // Header of the next frame carries the already
                                // incremented count.
                                state   <= HDR;
                                outSof  <= 1'b1;
                                outData <= frameCnt + 1'b1;
                            end else begin
                                state    <= IDLE;
                                outValid <= 1'b0;
                                outSof   <= 1'b0;
                                outData  <= '0;
                            end
                        end else begin
                            idx     <= idxNext;
                            outData <= shadow[idxNext];
                            outEof  <= (idxNext == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peak_readout.sv
// tb_peak_readout: randomized and directed stimulus against a frame-level
// reference model. The driver predicts every output word into a queue; a
// separate monitor pops and compares on each stream transfer.

module tb_peak_readout;

    localparam int NP  = 10;
    localparam int PIX = 3;
    localparam int PW  = NP * PIX;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic [PW-1:0] peakIn = '0;
    logic          peakValid = 1'b0;
    logic          outReady = 1'b0;
    logic          clrOvr = 1'b0;
    logic [NP-1:0] outData;
    logic          outValid;
    logic          outSof;
    logic          outEof;
    logic          busy;
    logic          overrun;

    peak_readout #(.NP(NP), .PIX(PIX)) dut (
        .clk       (clk),
        .res       (res),
        .peakIn    (peakIn),
        .peakValid (peakValid),
        .outData   (outData),
        .outValid  (outValid),
        .outReady  (outReady),
        .outSof    (outSof),
        .outEof    (outEof),
        .busy      (busy),
        .overrun   (overrun),
        .clrOvr    (clrOvr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NP-1:0] d;
        logic          s;
        logic          e;
    } wordT;

    wordT          expQ[$];
    int            checks = 0;
    int            failures = 0;
    int            words = 0;

    // Reference model: words still owed by the stream, next header value and
    // the overrun/busy state predicted for the edge just taken and the next one.
    int            rem = 0;
    logic [NP-1:0] frameNum = '0;
    logic          ovrPend = 1'b0;
    logic          ovrNow = 1'b0;
    logic          busyPend = 1'b0;
    logic          busyNow = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict its effect, then advance to the next
    // sampling point (2 time units after the rising edge).
    task automatic step(input bit pv, input logic [PW-1:0] pin, input bit rdy, input bit clr);
        bit xfer;
        bit acc;
        peakValid = pv;
        peakIn    = pin;
        outReady  = rdy;
        clrOvr    = clr;
        xfer = (rem > 0) && rdy;
        acc  = pv && ((rem == 0) || (rem == 1 && xfer));
        if (xfer) rem--;
        if (acc) begin
            expQ.push_back('{d: frameNum, s: 1'b1, e: 1'b0});
            for (int i = 0; i < PIX; i++) begin
                expQ.push_back('{d: pin[i*NP +: NP], s: 1'b0, e: (i == PIX - 1)});
            end
            rem += PIX + 1;
            frameNum = frameNum + 1'b1;
        end
        if (pv && !acc) ovrPend = 1'b1;
        else if (clr)   ovrPend = 1'b0;
        busyPend = (rem > 0);
        @(posedge clk);
        #2;
        ovrNow  = ovrPend;
        busyNow = busyPend;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
    endtask

    // Assert reset mid-cycle, check the outputs clear without a clock edge,
    // then release so the following step lands on the first edge after release.
    task automatic doReset();
        res = 1'b0;
        #1;
        chk("async_rst_valid", int'(outValid), 0);
        chk("async_rst_data",  int'(outData),  0);
        chk("async_rst_sofeof", int'({outSof, outEof}), 0);
        chk("async_rst_busy",  int'(busy),     0);
        chk("async_rst_ovr",   int'(overrun),  0);
        expQ.delete();
        rem = 0;
        frameNum = '0;
        ovrPend = 1'b0;
        ovrNow = 1'b0;
        busyPend = 1'b0;
        busyNow = 1'b0;
        peakValid = 1'b0;
        outReady = 1'b0;
        clrOvr = 1'b0;
        @(posedge clk);
        #2;
        res = 1'b1;
    endtask

    // Monitor: protocol rules every cycle, scoreboard pop on each transfer.
    logic          prevStall = 1'b0;
    logic [NP+2:0] heldWord = '0;

    always @(negedge clk) begin
        if (!res) begin
            prevStall <= 1'b0;
        end else begin
            chk("busy", int'(busy), int'(busyNow));
            chk("overrun", int'(overrun), int'(ovrNow));
            chk("out_valid", int'(outValid), int'(busyNow));
            if (!outValid) begin
                chk("idle_outputs_zero", int'({outData, outSof, outEof}), 0);
            end else begin
                chk("sof_eof_exclusive", int'(outSof & outEof), 0);
            end
            if (prevStall) begin
                chk("stall_hold", int'({outValid, outData, outSof, outEof}), int'(heldWord));
            end
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0d required=none at %0t", outData, $time);
                end else begin
                    wordT w;
                    w = expQ.pop_front();
                    words++;
                    chk("word", int'({outData, outSof, outEof}), int'({w.d, w.s, w.e}));
                end
            end
            prevStall <= outValid && !outReady;
            heldWord  <= {outValid, outData, outSof, outEof};
        end
    end

    initial begin
        logic [PW-1:0] frameA;
        logic [PW-1:0] frameB;
        logic [PW-1:0] frameC;
        bit            rdySeq [7];
        frameA = {10'd90, 10'd1022, 10'd108};
        frameB = {10'd500, 10'd1000, 10'd300};
        frameC = {10'd1, 10'd2, 10'd3};
        rdySeq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        #1 res = 1'b0;
        @(posedge clk);
        #2;
        doReset();

        // Basic frame: header 0 appears one cycle after the strobe.
        step(1'b1, frameA, 1'b1, 1'b0);
        chk("hdr_latency_valid", int'(outValid), 1);
        chk("hdr_latency_sof", int'(outSof), 1);
        chk("hdr_first_value", int'(outData), 0);
        idle(6, 1'b1);
        chk("busy_after_frame", int'(busy), 0);

        // Backpressure pattern on the same frame.
        step(1'b1, frameA, 1'b0, 1'b0);
        foreach (rdySeq[i]) step(1'b0, '0, rdySeq[i], 1'b0);
        idle(4, 1'b1);

        // Overrun: strobe during DATA is dropped; clear; clear racing a drop.
        step(1'b1, frameA, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, frameC, 1'b1, 1'b0);
        idle(4, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, frameA, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, frameC, 1'b1, 1'b1);
        idle(4, 1'b1);
        chk("overrun_sticky_vs_clear", int'(overrun), 1);
        step(1'b0, '0, 1'b1, 1'b1);

        // Back-to-back: second strobe on the EOF transfer cycle.
        step(1'b1, frameA, 1'b1, 1'b0);
        idle(3, 1'b1);
        step(1'b1, frameB, 1'b1, 1'b0);
        chk("b2b_no_bubble_sof", int'(outSof & outValid), 1);
        idle(6, 1'b1);

        // Wrap the frame counter with more than 1024 back-to-back frames.
        for (int i = 0; i < 1030 * (PIX + 1); i++) begin
            step(rem <= 1, PW'($urandom), 1'b1, 1'b0);
        end
        idle(6, 1'b1);

        // Reset in the middle of a frame, then strobe on the first edge after.
        step(1'b1, frameA, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        doReset();
        step(1'b1, frameB, 1'b0, 1'b0);
        chk("post_rst_hdr_valid", int'(outValid), 1);
        chk("post_rst_hdr_value", int'(outData), 0);
        idle(6, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 7) == 0, PW'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        idle(2 * (PIX + 1), 1'b1);

        chk("queue_drained", expQ.size(), 0);
        chk("words_seen_nonzero", int'(words > 1000), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
